// File: rtl/cam_simd_loader.sv
// Batch loader for cam_simd: gathers LANES operand pairs, strobes one CAM write,
// then walks the search keys through every lane, holding each for SEARCH_CYCLES.
module cam_simd_loader #(
    parameter int LANES         = 8,
    parameter int DW            = 4,
    parameter int SEARCH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DW-1:0]              in_L,
    input  logic [DW-1:0]              in_R,
    input  logic [1:0]                 in_op,
    output logic                       write_en,
    output logic [LANES*DW-1:0]        data_L,
    output logic [LANES*DW-1:0]        data_R,
    output logic [3:0]                 data_and,
    output logic [7:0]                 data_or,
    output logic [11:0]                data_xor,
    output logic [1:0]                 controller,
    output logic [DW-1:0]              pe_reg_L,
    output logic [DW-1:0]              pe_reg_R,
    output logic [$clog2(LANES)-1:0]   key_idx,
    output logic                       key_strobe,
    output logic                       done,
    output logic                       err,
    output logic                       busy
);

    // state  | meaning
    // IDLE   | waiting for the first beat of a batch
    // FILL   | collecting the remaining beats into lanes 1..LANES-1
    // WRITE  | single-cycle CAM load strobe
    // SEARCH | stepping keys through lanes, SEARCH_CYCLES per key
    // DONE   | single-cycle completion (err set for unsupported add)
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        WRITE  = 3'd2,
        SEARCH = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int KW = $clog2(LANES);
    localparam int HW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
    localparam logic [1:0] OP_ADD = 2'b11;

    state_t                 state_q, state_d;
    logic [KW-1:0]          count_q, count_d;
    logic [1:0]             op_q, op_d;
    logic [HW-1:0]          hold_q, hold_d;
    logic [KW-1:0]          key_idx_q, key_idx_d;
    logic [LANES*DW-1:0]    data_L_q, data_L_d, data_R_q, data_R_d;
    logic                   in_ready_q, in_ready_d, write_en_q, write_en_d;
    logic                   key_strobe_q, key_strobe_d, done_q, done_d;
    logic                   err_q, err_d, busy_q, busy_d;
    logic [3:0]             data_and_q, data_and_d;
    logic [7:0]             data_or_q, data_or_d;
    logic [11:0]            data_xor_q, data_xor_d;
    logic [1:0]             controller_q, controller_d;
    logic [DW-1:0]          pe_reg_L_q, pe_reg_L_d, pe_reg_R_q, pe_reg_R_d;
    logic                   accept;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        op_d         = op_q;
        hold_d       = hold_q;
        key_idx_d    = key_idx_q;
        data_L_d     = data_L_q;
        data_R_d     = data_R_q;
        data_and_d   = data_and_q;
        data_or_d    = data_or_q;
        data_xor_d   = data_xor_q;
        controller_d = controller_q;
        pe_reg_L_d   = pe_reg_L_q;
        pe_reg_R_d   = pe_reg_R_q;

        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_d              = in_op;
                        data_L_d[0 +: DW] = in_L;
                        data_R_d[0 +: DW] = in_R;
                        count_d           = KW'(1);
                        state_d           = FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        data_L_d[count_q*DW +: DW] = in_L;
                        data_R_d[count_q*DW +: DW] = in_R;
                        if (count_q == KW'(LANES-1)) begin
                            count_d = '0;
                            state_d = (op_q == OP_ADD) ? DONE : WRITE;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_d   = SEARCH;
                    key_idx_d = '0;
                    hold_d    = HW'(SEARCH_CYCLES-1);
                end
                SEARCH: begin
                    // hold is a down-counter; the key is complete at terminal count
                    if (hold_q == '0) begin
                        if (key_idx_q == KW'(LANES-1)) begin
                            state_d = DONE;
                        end else begin
                            key_idx_d = key_idx_q + 1'b1;
                            hold_d    = HW'(SEARCH_CYCLES-1);
                        end
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        in_ready_d   = (state_d == IDLE) || (state_d == FILL);
        busy_d       = (state_d != IDLE);
        write_en_d   = (state_d == WRITE);
        done_d       = (state_d == DONE);
        err_d        = done_d && (op_q == OP_ADD);
        key_strobe_d = 1'b0;

        if (state_d == WRITE) begin
            data_and_d = 4'b1000;
            data_or_d  = 8'b1110_0000;
            data_xor_d = 12'b0110_0000_0000;
        end
        if (state_d == SEARCH) begin
            pe_reg_L_d   = data_L_q[key_idx_d*DW +: DW];
            pe_reg_R_d   = data_R_q[key_idx_d*DW +: DW];
            controller_d = op_q;
            key_strobe_d = (hold_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            op_q         <= '0;
            hold_q       <= '0;
            key_idx_q    <= '0;
            data_L_q     <= '0;
            data_R_q     <= '0;
            in_ready_q   <= 1'b0;
            write_en_q   <= 1'b0;
            key_strobe_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            data_and_q   <= '0;
            data_or_q    <= '0;
            data_xor_q   <= '0;
            controller_q <= '0;
            pe_reg_L_q   <= '0;
            pe_reg_R_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            op_q         <= op_d;
            hold_q       <= hold_d;
            key_idx_q    <= key_idx_d;
            data_L_q     <= data_L_d;
            data_R_q     <= data_R_d;
            in_ready_q   <= in_ready_d;
            write_en_q   <= write_en_d;
            key_strobe_q <= key_strobe_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            data_and_q   <= data_and_d;
            data_or_q    <= data_or_d;
            data_xor_q   <= data_xor_d;
            controller_q <= controller_d;
            pe_reg_L_q   <= pe_reg_L_d;
            pe_reg_R_q   <= pe_reg_R_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign write_en   = write_en_q;
    assign data_L     = data_L_q;
    assign data_R     = data_R_q;
    assign data_and   = data_and_q;
    assign data_or    = data_or_q;
    assign data_xor   = data_xor_q;
    assign controller = controller_q;
    assign pe_reg_L   = pe_reg_L_q;
    assign pe_reg_R   = pe_reg_R_q;
    assign key_idx    = key_idx_q;
    assign key_strobe = key_strobe_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cam_simd_loader.sv
// Bench for cam_simd_loader: fixed batch table, reset/flush sequences and random batches,
// with expected timing derived from the cycle count since the final accepted beat.
module tb_cam_simd_loader;
    localparam int LANES = 8;
    localparam int DW    = 4;
    localparam int SC    = 2;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [3:0]  in_L = '0, in_R = '0;
    logic [1:0]  in_op = '0;
    logic        in_ready, write_en, key_strobe, done, err, busy;
    logic [31:0] data_L, data_R;
    logic [3:0]  data_and;
    logic [7:0]  data_or;
    logic [11:0] data_xor;
    logic [1:0]  controller;
    logic [3:0]  pe_reg_L, pe_reg_R;
    logic [2:0]  key_idx;

    cam_simd_loader #(.LANES(LANES), .DW(DW), .SEARCH_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_L(in_L), .in_R(in_R), .in_op(in_op), .write_en(write_en),
        .data_L(data_L), .data_R(data_R), .data_and(data_and), .data_or(data_or),
        .data_xor(data_xor), .controller(controller), .pe_reg_L(pe_reg_L), .pe_reg_R(pe_reg_R),
        .key_idx(key_idx), .key_strobe(key_strobe), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    // expected lane contents: each accepted beat overwrites its lane, nothing else does
    logic [31:0] cur_L = '0, cur_R = '0;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [1:0]  op;
        logic [15:0] gapv;   // 2 bits per beat: idle cycles inserted before that beat
        logic [3:0]  e_l3;
        logic [3:0]  e_r3;
        logic        e_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, in_ready, 0);   chk({tag, "_wen"}, write_en, 0);
        chk({tag, "_busy"}, busy, 0);        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);          chk({tag, "_ks"}, key_strobe, 0);
        chk({tag, "_dL"}, data_L, 0);        chk({tag, "_dR"}, data_R, 0);
        chk({tag, "_and"}, data_and, 0);     chk({tag, "_or"}, data_or, 0);
        chk({tag, "_xor"}, data_xor, 0);     chk({tag, "_ctl"}, controller, 0);
        chk({tag, "_peL"}, pe_reg_L, 0);     chk({tag, "_peR"}, pe_reg_R, 0);
        chk({tag, "_kidx"}, key_idx, 0);
    endtask

    task automatic run_batch(input logic [31:0] l, input logic [31:0] r, input logic [1:0] op,
                             input logic [15:0] gapv, input logic exp_err);
        for (int i = 0; i < LANES; i++) begin
            in_valid = 1'b0;
            for (int g = 0; g < int'(gapv[2*i +: 2]); g++) begin
                tick();
                chk("stall_ready", in_ready, 1);
                chk("stall_wen", write_en, 0);
                chk("stall_dL", data_L, cur_L);
            end
            in_valid = 1'b1;
            in_L     = l[4*i +: 4];
            in_R     = r[4*i +: 4];
            in_op    = (i == 0) ? op : 2'($urandom);
            tick();
            cur_L[4*i +: 4] = l[4*i +: 4];
            cur_R[4*i +: 4] = r[4*i +: 4];
            in_valid = 1'b0;
            chk("fill_dL", data_L, cur_L);
            chk("fill_dR", data_R, cur_R);
            if (i < LANES-1) begin
                chk("fill_ready", in_ready, 1);
                chk("fill_busy", busy, 1);
                chk("fill_wen", write_en, 0);
            end
        end
        if (exp_err) begin
            chk("err_done", done, 1);   chk("err_err", err, 1);
            chk("err_wen", write_en, 0); chk("err_ready", in_ready, 0);
            in_valid = 1'b1;
            in_L     = 4'($urandom);
            tick();
            in_valid = 1'b0;
            chk("err_idle_busy", busy, 0);  chk("err_idle_ready", in_ready, 1);
            chk("err_idle_done", done, 0);  chk("err_idle_err", err, 0);
            chk("err_idle_dL", data_L, cur_L);
        end else begin
            chk("wr_wen", write_en, 1);     chk("wr_ready", in_ready, 0);
            chk("wr_busy", busy, 1);        chk("wr_done", done, 0);
            chk("wr_and", data_and, 4'b1000);
            chk("wr_or", data_or, 8'b1110_0000);
            chk("wr_xor", data_xor, 12'b0110_0000_0000);
            chk("wr_dL", data_L, cur_L);    chk("wr_dR", data_R, cur_R);
            for (int k = 0; k < LANES; k++) begin
                for (int h = 0; h < SC; h++) begin
                    in_valid = 1'($urandom);
                    in_L     = 4'($urandom);
                    tick();
                    chk("srch_wen", write_en, 0);
                    chk("srch_ready", in_ready, 0);
                    chk("srch_done", done, 0);
                    chk("srch_ks", key_strobe, (h == SC-1));
                    if (h == SC-1) begin
                        chk("srch_kidx", key_idx, k);
                        chk("srch_peL", pe_reg_L, cur_L[4*k +: 4]);
                        chk("srch_peR", pe_reg_R, cur_R[4*k +: 4]);
                        chk("srch_ctl", controller, op);
                    end
                end
            end
            in_valid = 1'b0;
            tick();
            chk("dn_done", done, 1);  chk("dn_err", err, 0);
            chk("dn_busy", busy, 1);  chk("dn_ks", key_strobe, 0);
            chk("dn_ready", in_ready, 0);
            tick();
            chk("idle_done", done, 0);  chk("idle_busy", busy, 0);
            chk("idle_ready", in_ready, 1);
            chk("idle_dL", data_L, cur_L);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [31:0] rl, rr;
        logic [1:0]  rop;

        tbl[0] = '{l:32'h7654_3210, r:32'h0123_4567, op:2'b00, gapv:16'h0000, e_l3:4'h3, e_r3:4'h4, e_err:1'b0};
        tbl[1] = '{l:32'h7654_3210, r:32'h0123_4567, op:2'b00, gapv:16'h0030, e_l3:4'h3, e_r3:4'h4, e_err:1'b0};
        tbl[2] = '{l:32'h89ab_cdef, r:32'hf0e1_d2c3, op:2'b10, gapv:16'h2004, e_l3:4'hc, e_r3:4'hd, e_err:1'b0};
        tbl[3] = '{l:32'h1111_2222, r:32'h3333_4444, op:2'b11, gapv:16'h0000, e_l3:4'h2, e_r3:4'h4, e_err:1'b1};
        tbl[4] = '{l:32'hfedc_ba98, r:32'h0000_ffff, op:2'b01, gapv:16'h0001, e_l3:4'hb, e_r3:4'hf, e_err:1'b0};

        // power-on reset, then reset again in the middle of a search
        tick(); tick();
        chk_zero("por");
        rst_n = 1'b1;
        tick();
        chk("por_rel_ready", in_ready, 1);
        for (int n = 0; n < LANES; n++) begin
            in_valid = 1'b1; in_L = 4'(n); in_R = 4'(7-n); in_op = 2'b00;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid_search_busy", busy, 1);
        rst_n = 1'b0;
        tick(); tick();
        chk_zero("rst");
        rst_n = 1'b1;
        tick();
        cur_L = '0; cur_R = '0;
        chk("rel_ready", in_ready, 1);  chk("rel_busy", busy, 0);
        chk("rel_wen", write_en, 0);    chk("rel_dL", data_L, 0);
        chk("rel_kidx", key_idx, 0);    chk("rel_ctl", controller, 0);

        for (int i = 0; i < 5; i++) begin
            run_batch(tbl[i].l, tbl[i].r, tbl[i].op, tbl[i].gapv, tbl[i].e_err);
            chk("tbl_lane3_L", data_L[15:12], tbl[i].e_l3);
            chk("tbl_lane3_R", data_R[15:12], tbl[i].e_r3);
        end

        // flush arriving with the 5th beat: beat dropped, earlier lanes untouched
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1; in_L = 4'($urandom); in_R = 4'($urandom); in_op = 2'b01;
            tick();
            cur_L[4*n +: 4] = in_L;
            cur_R[4*n +: 4] = in_R;
        end
        in_valid = 1'b1; in_L = ~cur_L[3:0]; in_R = ~cur_R[3:0]; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_busy", busy, 0);     chk("fl_ready", in_ready, 1);
        chk("fl_wen", write_en, 0);  chk("fl_done", done, 0);
        chk("fl_dL", data_L, cur_L); chk("fl_dR", data_R, cur_R);
        tick();
        chk("fl_idle_busy", busy, 0);
        run_batch(32'h0f1e_2d3c, 32'h4b5a_6978, 2'b10, 16'h0000, 1'b0);

        for (int b = 0; b < 8; b++) begin
            rl  = $urandom;
            rr  = $urandom;
            rop = 2'($urandom_range(0, 3));
            run_batch(rl, rr, rop, 16'($urandom), (rop == 2'b11));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
